// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_arbiter slice: FSM states, select
// geometry and the reset value of the round-robin pointer.
package mux_arb_pkg;

    localparam int SEL_W = 2;
    localparam int N_REQ = 4;

    // Pointer starts at 3 so that source 0 has first priority after reset.
    localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] one_hot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way winner picker: round-robin from last+1 by default,
// fixed priority (lowest index wins) when MUX_ARB_FIXED_PRIO_EN is defined.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] win,
    output logic             any
);

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        win = '0;
        any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = SEL_W'(i);
        end
    end
`else
    logic [SEL_W-1:0] idx;

    always_comb begin
        win = '0;
        idx = '0;
        any = |req;
        // Scan from farthest to nearest so the source just after last wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = last + SEL_W'(k + 1);
            if (req[idx]) win = idx;
        end
    end
`endif

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a registered 4:1 select, capture and valid/ready
// output stage. Define MUX_ARB_FIXED_PRIO_EN for fixed priority (source 0 high).
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       out_src,
    output logic [1:0]       sel,
    output logic [3:0]       gnt
);

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] win;
    logic             any;
    logic [WIDTH-1:0] sel_data;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign last = LAST_RST;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= LAST_RST;
        end else if (state == HOLD && out_ready) begin
            last <= out_src;
        end
    end
`endif

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        sel_data = data0;
        case (sel)
            2'd0: sel_data = data0;
            2'd1: sel_data = data1;
            2'd2: sel_data = data2;
            2'd3: sel_data = data3;
            default: sel_data = data0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
            gnt       <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        sel   <= win;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_data  <= sel_data;
                    out_src   <= sel;
                    out_valid <= 1'b1;
                    gnt       <= one_hot(sel);
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
